branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 107 ++++++++++
 tb/tb_branch_predict_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
`default_nettype none
// branch_predict_unit: table of 2-bit saturating counters indexed by PC, with branch resolution.
// Optional macro BPU_STATS_EN adds saturating branch/mispredict counters. Rev 1.0
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_pred,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Sign,
  input  logic        Overflow,
  input  logic        Carry,
  input  logic [4:0]  opcode,
  input  logic [2:0]  function3,
  output logic        Decision,
  output logic        mispredict,
  output logic        mispredict_q
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
`endif
);

  localparam logic [4:0] OP_BRANCH = 5'b11000;

  logic [1:0]       counters [ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic [1:0]       resolve_cnt;
  logic             is_br;
  logic             unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign resolve_idx    = resolve_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                            resolve_pc[31:IDX_W+2], resolve_pc[1:0]};

  // No bypass: a same-cycle update to the fetch index is seen one cycle later
  assign pred_taken  = counters[fetch_idx][1];
  assign resolve_cnt = counters[resolve_idx];

  assign is_br      = resolve_valid & Branch & (opcode == OP_BRANCH);
  assign mispredict = is_br & (Decision != resolve_pred);

  always_comb begin
    Decision = 1'b0;
    if (is_br) begin
      case (function3)
        3'b000:  Decision = Zero;
        3'b001:  Decision = ~Zero;
        3'b100:  Decision = Sign ^ Overflow;
        3'b101:  Decision = ~(Sign ^ Overflow);
        3'b110:  Decision = ~Carry;
        3'b111:  Decision = Carry;
        default: Decision = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counters[i] <= 2'b01;
      end
    end else if (is_br) begin
      if (Decision && (resolve_cnt != 2'b11)) begin
        counters[resolve_idx] <= resolve_cnt + 2'b01;
      end else if (!Decision && (resolve_cnt != 2'b00)) begin
        counters[resolve_idx] <= resolve_cnt - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispredict;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count <= 32'd0;
      mp_count <= 32'd0;
    end else begin
      if (is_br && (br_count != 32'hFFFF_FFFF)) begin
        br_count <= br_count + 32'd1;
      end
      if (mispredict && (mp_count != 32'hFFFF_FFFF)) begin
        mp_count <= mp_count + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// tb_branch_predict_unit: directed vectors with hand-computed expectations for branch_predict_unit.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        pred_taken;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = 32'h0;
  logic        resolve_pred = 1'b0;
  logic        Branch = 1'b0, Zero = 1'b0, Sign = 1'b0, Overflow = 1'b0, Carry = 1'b0;
  logic [4:0]  opcode = 5'b0;
  logic [2:0]  function3 = 3'b0;
  logic        Decision, mispredict, mispredict_q;
`ifdef BPU_STATS_EN
  logic [31:0] br_count, mp_count;
`endif

  int vecs = 0;
  int miscompares = 0;

  localparam logic [4:0] OP_BR  = 5'b11000;
  localparam logic [4:0] OP_ALU = 5'b01100;

  branch_predict_unit #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_pred(resolve_pred),
    .Branch(Branch), .Zero(Zero), .Sign(Sign), .Overflow(Overflow), .Carry(Carry),
    .opcode(opcode), .function3(function3), .Decision(Decision),
    .mispredict(mispredict), .mispredict_q(mispredict_q)
`ifdef BPU_STATS_EN
    , .br_count(br_count), .mp_count(mp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic pred, input logic [4:0] op,
                       input logic [2:0] f3, input logic br, input logic z, input logic s,
                       input logic o, input logic c);
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    resolve_pred  = pred;
    opcode        = op;
    function3     = f3;
    Branch        = br;
    Zero          = z;
    Sign          = s;
    Overflow      = o;
    Carry         = c;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    Branch        = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string tag, input logic [2:0] f3, input logic z, input logic s,
                     input logic o, input logic c, input logic exp);
    drive(32'h3C, 1'b0, OP_BR, f3, 1'b1, z, s, o, c);
    #1;
    chk(tag, Decision, exp);
    chk({tag, "_mp"}, mispredict, exp);
    edge1();
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset asserted away from any clock edge
    #2 rst = 1'b1;
    fetch_pc = 32'h40;
    #1;
    chk("rst_pred_40", pred_taken, 1'b0);
    chk("rst_mpq", mispredict_q, 1'b0);
    edge1();
    edge1();
    rst = 1'b0;
    #1;
    chk("post_rst_pred_40", pred_taken, 1'b0);

    // Taken BEQ predicted not-taken
    drive(32'h40, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("beq_decision", Decision, 1'b1);
    chk("beq_mispredict", mispredict, 1'b1);
    chk("beq_mpq_before", mispredict_q, 1'b0);
    edge1();
    idle();
    #1;
    chk("beq_mpq", mispredict_q, 1'b1);
    chk("beq_pred_40", pred_taken, 1'b1);
    edge1();
    chk("idle_mpq", mispredict_q, 1'b0);

    // BNE at 0x44: 01->10->11->11, then not-taken twice: ->10->01
    fetch_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      drive(32'h44, 1'b1, OP_BR, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bne_t_decision", Decision, 1'b1);
      chk("bne_t_mispredict", mispredict, 1'b0);
      edge1();
      chk("bne_t_pred", pred_taken, 1'b1);
    end
    drive(32'h44, 1'b1, OP_BR, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bne_nt_decision", Decision, 1'b0);
    chk("bne_nt_mispredict", mispredict, 1'b1);
    edge1();
    chk("bne_sat_pred", pred_taken, 1'b1);
    edge1();
    chk("bne_nt2_pred", pred_taken, 1'b0);

    // Non-branch cycles leave the table alone (entry 0x44 is 01)
    drive(32'h44, 1'b0, OP_ALU, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alu_decision", Decision, 1'b0);
    chk("alu_mispredict", mispredict, 1'b0);
    edge1();
    chk("alu_pred", pred_taken, 1'b0);
    drive(32'h44, 1'b0, OP_BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("nobranch_decision", Decision, 1'b0);
    edge1();
    drive(32'h44, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve_valid = 1'b0;
    #1;
    chk("novalid_decision", Decision, 1'b0);
    edge1();
    chk("noupd_pred", pred_taken, 1'b0);

    // Illegal f3 counts as not-taken: 01->00, then one taken -> 01 (still NT)
    drive(32'h44, 1'b1, OP_BR, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("illegal_decision", Decision, 1'b0);
    chk("illegal_mispredict", mispredict, 1'b1);
    edge1();
    drive(32'h44, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    edge1();
    chk("illegal_upd_pred", pred_taken, 1'b0);

    // Condition decode
    dec("f3_000_z0",   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dec("f3_001_z1",   3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    dec("f3_100_s1o0", 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    dec("f3_100_s1o1", 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    dec("f3_101_s0o0", 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dec("f3_101_s1o0", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dec("f3_110_c0",   3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dec("f3_110_c1",   3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dec("f3_111_c1",   3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    dec("f3_111_c0",   3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dec("f3_011",      3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Async reset clears mispredict_q and the table without a clock
    fetch_pc = 32'h40;
    drive(32'h40, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    edge1();
    chk("pre_arst_mpq", mispredict_q, 1'b1);
    chk("pre_arst_pred", pred_taken, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mpq", mispredict_q, 1'b0);
    chk("arst_pred", pred_taken, 1'b0);
    // Taken update pending across an edge while reset is held is discarded
    edge1();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_discard_pred", pred_taken, 1'b0);

    // Aliasing: 0x40 and 0x00 share index 0
    fetch_pc = 32'h00;
    drive(32'h40, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alias_pred_before", pred_taken, 1'b0);
    edge1();
    idle();
    #1;
    chk("alias_pred_after", pred_taken, 1'b1);

    // Same-cycle fetch/resolve at 0x80 after a fresh reset: no bypass
    pulse_reset();
    fetch_pc = 32'h80;
    drive(32'h80, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("same_cycle_pred", pred_taken, 1'b0);
    edge1();
    idle();
    #1;
    chk("next_cycle_pred", pred_taken, 1'b1);

`ifdef BPU_STATS_EN
    pulse_reset();
    chk32("stats_rst_br", br_count, 32'd0);
    chk32("stats_rst_mp", mp_count, 32'd0);
    fetch_pc = 32'h3C;
    // Entry 15: 01->10->11->10->01->10; mispredicts on the 2nd and 4th
    drive(32'h3C, 1'b1, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); edge1();
    drive(32'h3C, 1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); edge1();
    drive(32'h3C, 1'b0, OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); edge1();
    drive(32'h3C, 1'b1, OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); edge1();
    drive(32'h3C, 1'b1, OP_BR, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); edge1();
    chk("stats_pred_before", pred_taken, 1'b1);
    drive(32'h3C, 1'b1, OP_ALU, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); edge1();
    idle();
    #1;
    chk("stats_pred_after", pred_taken, 1'b1);
    chk32("stats_br", br_count, 32'd5);
    chk32("stats_mp", mp_count, 32'd2);
    edge1();
    chk32("stats_br_hold", br_count, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
